// File: rtl/instr_mem.sv
// Word-indexed instruction memory: combinational read, synchronous program load.
// Define BYTE_ADDR_EN to use byte addresses on Address and prog_addr.
module instr_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  addr_err,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [INST_WIDTH-1:0] prog_data
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(IMEM_DEPTH);
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

    localparam logic [INST_WIDTH-1:0] IMAGE [IMEM_DEPTH] = '{
        0:  INST_WIDTH'(32'h003100B3),
        1:  INST_WIDTH'(32'h00200113),
        2:  INST_WIDTH'(32'h00C00193),
        3:  INST_WIDTH'(32'h403100B3),
        4:  INST_WIDTH'(32'h00310233),
        5:  INST_WIDTH'(32'h002212B3),
        6:  INST_WIDTH'(32'h00208113),
        7:  INST_WIDTH'(32'h00000113),
        8:  INST_WIDTH'(32'h001120A3),
        9:  INST_WIDTH'(32'h00112203),
        10: INST_WIDTH'(32'h00320293),
        11: INST_WIDTH'(32'h00900293),
        12: INST_WIDTH'(32'h00900313),
        13: INST_WIDTH'(32'h00628463),
        14: INST_WIDTH'(32'hFF608213),
        15: INST_WIDTH'(32'h00C00193),
        17: INST_WIDTH'(32'hFFB20293),
        18: INST_WIDTH'(32'h014000EF),
        19: INST_WIDTH'(32'hFFB08093),
        20: INST_WIDTH'(32'h00200113),
        28: INST_WIDTH'(32'hFF608193),
        default: NOP
    };

    // Power-up contents match the reset image so fetch is valid from time 0.
    logic [INST_WIDTH-1:0] mem_q [IMEM_DEPTH] = IMAGE;

    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  rd_ok;
    logic                  wr_ok;

    // Decode read/write addresses into word indices and legality flags.
    always_comb begin
`ifdef BYTE_ADDR_EN
        rd_idx = Address >> 2;
        wr_idx = prog_addr >> 2;
        rd_ok  = (Address[1:0] == 2'b00) && ({1'b0, rd_idx} < DEPTH_W);
        wr_ok  = (prog_addr[1:0] == 2'b00) && ({1'b0, wr_idx} < DEPTH_W);
`else
        rd_idx = Address;
        wr_idx = prog_addr;
        rd_ok  = {1'b0, rd_idx} < DEPTH_W;
        wr_ok  = {1'b0, wr_idx} < DEPTH_W;
`endif
    end

    assign instruction = rd_ok ? mem_q[rd_idx[AW-1:0]] : NOP;
    assign addr_err    = ~rd_ok;

    // Reset reloads the full image in one cycle; otherwise apply program writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= IMAGE;
        end else if (prog_we && wr_ok) begin
            mem_q[wr_idx[AW-1:0]] <= prog_data;
        end
    end

endmodule

// File: tb/tb_instr_mem.sv
// Scoreboard bench for instr_mem: stimulus queues expectations,
// a monitor process pops and compares after each strobe.
module tb_instr_mem;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef BYTE_ADDR_EN
    localparam int SH = 2;
`else
    localparam int SH = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] instruction;
    logic        addr_err;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic        err;
        string       nm;
    } exp_t;

    exp_t q[$];
    event smp;

    instr_mem dut (
        .clk         (clk),
        .rst         (rst),
        .Address     (Address),
        .instruction (instruction),
        .addr_err    (addr_err),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wa(input int idx);
        return 32'(idx) << SH;
    endfunction

    // Monitor: compare the presented output against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(smp);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL no_expectation: got %h/%b", instruction, addr_err);
            end else begin
                e = q.pop_front();
                if (instruction !== e.ins || addr_err !== e.err) begin
                    errors++;
                    $display("FAIL %s: got ins=%h err=%b, want ins=%h err=%b",
                             e.nm, instruction, addr_err, e.ins, e.err);
                end
            end
        end
    end

    task automatic expect_now(input logic [31:0] ins, input logic err,
                              input string nm);
        exp_t e;
        e.ins = ins;
        e.err = err;
        e.nm  = nm;
        q.push_back(e);
        ->smp;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ins,
                      input logic err, input string nm);
        Address = a;
        expect_now(ins, err, nm);
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    initial begin : stim
        @(negedge clk);
        rd(wa(0), 32'h003100B3, 1'b0, "pre_reset_0");
        rd(wa(28), 32'hFF608193, 1'b0, "pre_reset_28");

        pulse_rst();
        rd(wa(0), 32'h003100B3, 1'b0, "rd0");
        rd(wa(1), 32'h00200113, 1'b0, "rd1");
        rd(wa(2), 32'h00C00193, 1'b0, "rd2");
        rd(wa(16), NOP, 1'b0, "rd16");
        rd(wa(28), 32'hFF608193, 1'b0, "rd28");
        rd(wa(1023), NOP, 1'b0, "rd1023");
        rd(wa(1024), NOP, 1'b1, "rd1024_oor");
        rd(wa(22), NOP, 1'b0, "rd22");
        rd(wa(14), 32'hFF608213, 1'b0, "rd14");

        // Write and read same address: old word before edge, new after.
        Address   = wa(5);
        prog_we   = 1'b1;
        prog_addr = wa(5);
        prog_data = 32'hDEADBEEF;
        expect_now(32'h002212B3, 1'b0, "wr5_before_edge");
        @(negedge clk);
        prog_we = 1'b0;
        rd(wa(5), 32'hDEADBEEF, 1'b0, "wr5_after_edge");
        rd(wa(4), 32'h00310233, 1'b0, "wr5_neighbour");
        pulse_rst();
        rd(wa(5), 32'h002212B3, 1'b0, "rst_restores5");

        // Reset and write on the same edge: reset wins.
        rst       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = wa(0);
        prog_data = 32'h12345678;
        @(negedge clk);
        rst     = 1'b0;
        prog_we = 1'b0;
        rd(wa(0), 32'h003100B3, 1'b0, "rst_wins");

        // Out-of-range write must not wrap onto index 0.
        wr(wa(1024), 32'hA5A5A5A5);
        rd(wa(0), 32'h003100B3, 1'b0, "oor_write_no_wrap");
        rd(wa(1024), NOP, 1'b1, "oor_write_read");

        // Highest in-range write lands.
        wr(wa(1023), 32'hCAFEF00D);
        rd(wa(1023), 32'hCAFEF00D, 1'b0, "wr1023");

        // Reset mid-load discards the partial program.
        wr(wa(1), 32'h11111111);
        wr(wa(2), 32'h22222222);
        rd(wa(2), 32'h22222222, 1'b0, "load_in_progress");
        prog_we   = 1'b1;
        prog_addr = wa(3);
        prog_data = 32'h33333333;
        rst       = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        prog_we = 1'b0;
        rd(wa(1), 32'h00200113, 1'b0, "midload_1");
        rd(wa(2), 32'h00C00193, 1'b0, "midload_2");
        rd(wa(3), 32'h403100B3, 1'b0, "midload_3");
        rd(wa(1023), NOP, 1'b0, "midload_1023");

`ifdef BYTE_ADDR_EN
        rd(32'd8, 32'h00C00193, 1'b0, "byte8");
        rd(32'd9, NOP, 1'b1, "byte9_misaligned");
        rd(32'd14, NOP, 1'b1, "byte14_misaligned");
        wr(32'd21, 32'hBADBAD00);
        rd(32'd20, 32'h002212B3, 1'b0, "misaligned_write_ignored");
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
